// File: rtl/ms_arbiter.sv
// Round-robin arbiter sharing one slave request port between NUM_MASTERS masters,
// with a per-transaction watchdog that aborts a stalled slave access.
module ms_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_data,
  output logic [NUM_MASTERS-1:0]            m_gnt,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic                              s_req,
  output logic [ADDR_W-1:0]                 s_addr,
  output logic [DATA_W-1:0]                 s_data,
  input  logic                              s_gnt,
  output logic [$clog2(NUM_MASTERS)-1:0]    owner,
  output logic                              busy
);

  // state | meaning
  // IDLE  | waiting for any m_req, arbitrates on the next edge
  // BUSY  | s_req driven, waiting for s_gnt or watchdog expiry
  // DONE  | one-cycle m_gnt pulse to the owner
  // ERR   | one-cycle m_err pulse to the owner

  localparam int OW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [OW-1:0] LAST_RST = OW'(NUM_MASTERS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_e;

  state_e            state_q, state_d;
  logic [OW-1:0]     last_q, last_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OW-1:0]     win;
  logic              win_vld;

  // first requester after the last owner, wrapping around
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      if (!win_vld && m_req[(int'(last_q) + off) % NUM_MASTERS]) begin
        win     = OW'((int'(last_q) + off) % NUM_MASTERS);
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      owner_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = BUSY;
          owner_d = win;
          addr_d  = m_addr[win*ADDR_W +: ADDR_W];
          data_d  = m_data[win*DATA_W +: DATA_W];
          cnt_d   = '0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // a grant on the final watchdog cycle still completes normally
        if (s_gnt) begin
          state_d = DONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ERR;
        end
      end
      DONE, ERR: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_gnt = '0;
    m_err = '0;
    s_req = (state_q == BUSY);
    busy  = (state_q != IDLE);
    if (state_q == DONE) m_gnt[owner_q] = 1'b1;
    if (state_q == ERR)  m_err[owner_q] = 1'b1;
  end

  assign s_addr = addr_q;
  assign s_data = data_q;
  assign owner  = owner_q;

endmodule

// File: tb/tb_ms_arbiter.sv
// Bench for ms_arbiter: directed vector table, reset/round-robin sequence, then
// randomized traffic checked against a transaction-level round-robin model.
module tb_ms_arbiter;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    m_req;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_data;
  logic [N-1:0]    m_gnt, m_err;
  logic            s_req;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_data;
  logic            s_gnt;
  logic [1:0]      owner;
  logic            busy;

  int total = 0;
  int bad   = 0;
  int last_m;

  always #5 clk = ~clk;

  ms_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .m_req(m_req), .m_addr(m_addr), .m_data(m_data),
    .m_gnt(m_gnt), .m_err(m_err), .s_req(s_req), .s_addr(s_addr), .s_data(s_data),
    .s_gnt(s_gnt), .owner(owner), .busy(busy)
  );

  typedef struct {
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    int              delay;
    int              exp_w;
    logic [AW-1:0]   exp_a;
    logic [DW-1:0]   exp_d;
    bit              exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // winner = first requester after 'last', found by rotating the request vector
  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    logic [2*N-1:0] dbl;
    dbl = {req, req} >> (last + 1);
    for (int k = 0; k < N; k++)
      if (dbl[k]) return (last + 1 + k) % N;
    return 0;
  endfunction

  task automatic stir(input int w);
    for (int i = 0; i < N; i++) begin
      if (!m_req[i]) begin
        m_addr[i*AW +: AW] = AW'($urandom);
        m_data[i*DW +: DW] = DW'($urandom);
        if (i != w && $urandom_range(0, 7) == 0) m_req[i] = 1'b1;
      end
    end
    if ($urandom_range(0, 9) == 0) m_req[w] = 1'b0;
  endtask

  // Called in an IDLE cycle with m_req already driven; returns in the following IDLE cycle.
  task automatic do_txn(input string tag, input int delay, input int w,
                        input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                        input bit eerr, input bit noise);
    int b;
    bit fin;
    logic [N-1:0] oh;
    oh = '0;
    oh[w] = 1'b1;
    chk({tag, " idle_busy"}, 32'(busy), 32'(0));
    chk({tag, " idle_sreq"}, 32'(s_req), 32'(0));
    s_gnt = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk); #1;
    b   = 1;
    fin = 1'b0;
    while (!fin) begin
      chk({tag, " busy_sreq"}, 32'(s_req), 32'(1));
      chk({tag, " busy_busy"}, 32'(busy), 32'(1));
      chk({tag, " busy_owner"}, 32'(owner), 32'(w));
      chk({tag, " busy_saddr"}, 32'(s_addr), 32'(ea));
      chk({tag, " busy_sdata"}, 32'(s_data), 32'(ed));
      chk({tag, " busy_mgnt"}, 32'(m_gnt), 32'(0));
      chk({tag, " busy_merr"}, 32'(m_err), 32'(0));
      s_gnt = (b == delay + 1);
      if (noise) stir(w);
      @(posedge clk); #1;
      if (s_gnt || b == TO) fin = 1'b1;
      else b++;
    end
    chk({tag, " end_sreq"}, 32'(s_req), 32'(0));
    chk({tag, " end_busy"}, 32'(busy), 32'(1));
    chk({tag, " end_mgnt"}, 32'(m_gnt), eerr ? 32'(0) : 32'(oh));
    chk({tag, " end_merr"}, 32'(m_err), eerr ? 32'(oh) : 32'(0));
    chk({tag, " end_saddr"}, 32'(s_addr), 32'(ea));
    s_gnt = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    m_req[w] = 1'b0;
    @(posedge clk); #1;
    chk({tag, " post_busy"}, 32'(busy), 32'(0));
    chk({tag, " post_sreq"}, 32'(s_req), 32'(0));
    chk({tag, " post_mgnt"}, 32'(m_gnt), 32'(0));
    chk({tag, " post_merr"}, 32'(m_err), 32'(0));
    chk({tag, " post_owner"}, 32'(owner), 32'(w));
    last_m = w;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b0100, 8'h20, 32'h00A5_0000,  0, 2, 2'd2, 8'hA5, 1'b0};
    vecs[1] = '{4'b1000, 8'hC0, 32'h3C00_0000,  2, 3, 2'd3, 8'h3C, 1'b0};
    vecs[2] = '{4'b1010, 8'h48, 32'h7700_5A00,  1, 1, 2'd2, 8'h5A, 1'b0};
    vecs[3] = '{4'b1000, 8'h40, 32'h7700_0000,  0, 3, 2'd1, 8'h77, 1'b0};
    vecs[4] = '{4'b0001, 8'h01, 32'h0000_00E1, 99, 0, 2'd1, 8'hE1, 1'b1};
    vecs[5] = '{4'b0011, 8'h0C, 32'h0000_2211, 15, 1, 2'd3, 8'h22, 1'b0};
    vecs[6] = '{4'b0001, 8'h00, 32'h0000_0011,  3, 0, 2'd0, 8'h11, 1'b0};
    vecs[7] = '{4'b0110, 8'h34, 32'h00C2_B100, 16, 1, 2'd1, 8'hB1, 1'b1};
    vecs[8] = '{4'b0100, 8'h30, 32'h00C2_0000, 14, 2, 2'd3, 8'hC2, 1'b0};

    m_req = '0; m_addr = '0; m_data = '0; s_gnt = 1'b0; rstn = 1'b0;
    last_m = N - 1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_sreq", 32'(s_req), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_owner", 32'(owner), 32'(0));
    chk("rst_mgnt", 32'(m_gnt), 32'(0));
    chk("rst_merr", 32'(m_err), 32'(0));
    chk("rst_saddr", 32'(s_addr), 32'(0));
    chk("rst_sdata", 32'(s_data), 32'(0));
    rstn = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_hold_busy", 32'(busy), 32'(0));
      chk("idle_hold_sreq", 32'(s_req), 32'(0));
    end

    for (int v = 0; v < 9; v++) begin
      m_req  = vecs[v].req;
      m_addr = vecs[v].addr;
      m_data = vecs[v].data;
      do_txn($sformatf("vec%0d", v), vecs[v].delay, vecs[v].exp_w, vecs[v].exp_a,
             vecs[v].exp_d, vecs[v].exp_err, 1'b0);
    end

    // reset in the third BUSY cycle of master 1's transaction
    m_req = 4'b0010; m_addr = 8'h0C; m_data = 32'h0000_6600; s_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_sreq", 32'(s_req), 32'(1));
    chk("mid_owner", 32'(owner), 32'(1));
    #2 rstn = 1'b0;
    #1;
    chk("arst_sreq", 32'(s_req), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_owner", 32'(owner), 32'(0));
    chk("arst_mgnt", 32'(m_gnt), 32'(0));
    chk("arst_merr", 32'(m_err), 32'(0));
    chk("arst_saddr", 32'(s_addr), 32'(0));
    @(posedge clk); #1;
    rstn   = 1'b1;
    last_m = N - 1;
    m_req  = 4'b1111; m_addr = 8'hE4; m_data = 32'h4433_2211;
    for (int k = 0; k < 6; k++) begin
      int w;
      w = k % N;
      do_txn($sformatf("rr%0d", k), 0, w, AW'(w), DW'(8'h11 * (w + 1)), 1'b0, 1'b0);
      m_req[w] = 1'b1;
    end

    for (int t = 0; t < 40; t++) begin
      int w, dly;
      for (int i = 0; i < N; i++) begin
        if (!m_req[i] && $urandom_range(0, 1) == 1) begin
          m_req[i] = 1'b1;
          m_addr[i*AW +: AW] = AW'($urandom);
          m_data[i*DW +: DW] = DW'($urandom);
        end
      end
      if (m_req == '0) begin
        w = $urandom_range(0, N - 1);
        m_req[w] = 1'b1;
        m_addr[w*AW +: AW] = AW'($urandom);
        m_data[w*DW +: DW] = DW'($urandom);
      end
      w   = rr_pick(m_req, last_m);
      dly = $urandom_range(0, 19);
      do_txn($sformatf("rand%0d", t), dly, w, m_addr[w*AW +: AW], m_data[w*DW +: DW],
             dly >= TO, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ms_arbiter.md
Name: ms_arbiter

Overview:
- Shares one ms_if slave port between NUM_MASTERS requesting masters.
- Round-robin arbitration picks one master. The arbiter latches that master's address and data, drives a single slave request, and routes the slave's grant back to the winner.
- A per-transaction watchdog aborts a stalled slave access and flags an error to the owning master.
- Sits between the master instances and the slave in d_top-style integrations.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8)
- ADDR_W, 2, slave address width
- DATA_W, 8, data width
- TIMEOUT, 16, max cycles in BUSY waiting for s_gnt before abort (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- m_req  in  NUM_MASTERS  per-master request; held high with addr/data stable until m_gnt or m_err
- m_addr  in  NUM_MASTERS*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W]
- m_data  in  NUM_MASTERS*DATA_W  packed write data; master i at [i*DATA_W +: DATA_W]
- m_gnt  out  NUM_MASTERS  one-hot, 1-cycle completion pulse to owner
- m_err  out  NUM_MASTERS  one-hot, 1-cycle timeout pulse to owner
- s_req  out  1  request to slave
- s_addr  out  ADDR_W  latched address to slave
- s_data  out  DATA_W  latched data to slave
- s_gnt  in  1  slave grant
- owner  out  $clog2(NUM_MASTERS)  index of current/last owner
- busy  out  1  high in any non-IDLE state

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE. All of the following are 0: m_gnt, m_err, s_req, s_addr, s_data, owner, busy, timeout counter. Round-robin pointer last=NUM_MASTERS-1, so master 0 has first priority.
- All outputs are registered or decoded from registered state; there is no combinational path from m_req or s_gnt to any output.
- IDLE:
  - If m_req != 0, pick the first set bit searching from (last+1) mod N upward with wrap-around.
  - Latch owner, s_addr and s_data from that master; clear the counter; go to BUSY.
  - If m_req == 0, stay in IDLE.
- BUSY:
  - s_req=1, busy=1. The counter increments each cycle.
  - If s_gnt=1, go to DONE.
  - Else if counter==TIMEOUT-1, go to ERR.
  - s_gnt and the timeout in the same cycle: the grant wins and the state goes to DONE.
- DONE (1 cycle): s_req=0, m_gnt[owner]=1, last<=owner, then go to IDLE.
- ERR (1 cycle): s_req=0, m_err[owner]=1, last<=owner, then go to IDLE.
- Latency:
  - m_req sampled high in IDLE at edge k gives s_req high in cycle k+1.
  - s_gnt sampled at edge j gives m_gnt high in cycle j+1.
  - Minimum transaction is 3 cycles: IDLE, BUSY, DONE.
- Master rule: drop m_req at the edge after seeing m_gnt or m_err. IDLE then re-arbitrates without re-granting the same master.
- Requests arriving or changing while not in IDLE are ignored until the next IDLE. s_addr and s_data stay constant through BUSY/DONE/ERR.
- s_gnt while in IDLE, DONE or ERR is ignored.
- A master that drops m_req mid-transaction does not cancel it; the transaction completes normally.
- rstn asserted mid-transaction returns the block to reset values immediately. No m_gnt or m_err is produced for the aborted transaction.
- owner holds its value after DONE/ERR until the next arbitration.

Test Plan:
- Single request: reset 5 clocks, then master 2 requests with addr=2'b10, data=8'hA5. The slave grants 1 cycle after s_req. Required: s_req high 1 cycle after m_req, s_addr=2, s_data=A5, m_gnt=4'b0100 for exactly 1 cycle, owner=2, busy drops after DONE.
- Round-robin fairness: all 4 masters hold m_req continuously (each re-asserts after its grant); the slave grants immediately. Required: grant order 0,1,2,3,0,1; each transaction takes 3 cycles.
- Wrap-around priority: last=3 from a prior grant; masters 1 and 3 request together. Required: master 1 wins first, then master 3.
- Timeout: s_gnt tied 0; master 0 requests. Required: s_req high for exactly 16 cycles, then m_err=4'b0001 for 1 cycle, no m_gnt pulse, return to IDLE. Next arbitration starts from master 1.
- Grant on last timeout cycle: s_gnt asserted in BUSY cycle 16. Required: m_gnt pulses and m_err stays 0.
- Reset mid-operation: deassert rstn in the 3rd BUSY cycle. Required: s_req, busy, owner, m_gnt and m_err all 0 immediately. After release, master 0 has top priority.
